cipher: RTL and testbench

- Iterative AES encryption round engine; the forward-direction counterpart of the decipher engine.
- Takes one 128-bit plaintext block and produces the ciphertext after rounds_total rounds, one round per clock.
- Receives round keys from the shared key-schedule store, which returns the key for round_no one cycle after round_no is presented.
- Sits beside the decipher engine in the AES core; supports AES-128, AES-192 and AES-256 through rounds_total = 10, 12 or 14.

---
 rtl/cipher_pkg.sv | 68 ++++++
 rtl/cipher_round.sv | 27 ++
 rtl/cipher.sv | 113 +++++++++++
 tb/tb_cipher.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared AES definitions for the forward round engine: widths, FSM encoding,
// forward S-box and GF(2^8) helpers.
package cipher_pkg;

  localparam int BLK_S          = 128;
  localparam int ROUND_KEY_BITS = 128;
  localparam int Nb             = 4;
  localparam int BYTE_S         = 8;
  localparam int WORD_S         = 32;

  typedef enum logic [1:0] {
    CIPHER_IDLE  = 2'd0,
    CIPHER_RUN   = 2'd1,
    CIPHER_DRAIN = 2'd2
  } cipher_state_e;

  // Forward S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [BYTE_S-1:0] get_byte(input logic [BLK_S-1:0] blk, input int i);
    return blk[BYTE_S*i +: BYTE_S];
  endfunction

  function automatic logic [WORD_S-1:0] get_word(input logic [BLK_S-1:0] blk, input int c);
    return blk[WORD_S*c +: WORD_S];
  endfunction

  function automatic logic [BYTE_S-1:0] get_sbox(input logic [BYTE_S-1:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [BYTE_S-1:0] gm2(input logic [BYTE_S-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_S-1:0] gm3(input logic [BYTE_S-1:0] b);
    return gm2(b) ^ b;
  endfunction

  // One column through the [2 3 1 1] circulant; row r sits in byte r.
  function automatic logic [WORD_S-1:0] mix_col(input logic [WORD_S-1:0] col);
    logic [WORD_S-1:0] res;
    logic [BYTE_S-1:0] a [4];
    res = '0;
    for (int r = 0; r < 4; r++) a[r] = col[BYTE_S*r +: BYTE_S];
    for (int r = 0; r < 4; r++)
      res[BYTE_S*r +: BYTE_S] = gm2(a[r]) ^ gm3(a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    return res;
  endfunction

endpackage

// File: rtl/cipher_round.sv
// Combinational AES forward round: SubBytes, ShiftRows, MixColumns (skipped
// on the last round) and AddRoundKey.
module cipher_round
  import cipher_pkg::*;
(
  input  logic [BLK_S-1:0]          state_i,
  input  logic [ROUND_KEY_BITS-1:0] round_key_i,
  input  logic                      last_i,
  output logic [BLK_S-1:0]          state_o
);

  logic [BLK_S-1:0] sub_w;
  logic [BLK_S-1:0] shift_w;
  logic [BLK_S-1:0] mix_w;

  always_comb begin
    sub_w   = '0;
    shift_w = '0;
    mix_w   = '0;
    for (int i = 0; i < 16; i++) sub_w[BYTE_S*i +: BYTE_S] = get_sbox(get_byte(state_i, i));
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (int i = 0; i < 16; i++) shift_w[BYTE_S*i +: BYTE_S] = get_byte(sub_w, (i + 4*(i%4)) % 16);
    for (int c = 0; c < Nb; c++) mix_w[WORD_S*c +: WORD_S] = mix_col(get_word(shift_w, c));
    state_o = (last_i ? shift_w : mix_w) ^ round_key_i;
  end

endmodule

// File: rtl/cipher.sv
// Iterative AES encryption engine, one round per clock, round keys fetched from
// an external store with one cycle of latency. CIPHER_RESTART_EN makes en while busy abort and restart.
module cipher
  import cipher_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [ROUND_KEY_BITS-1:0] round_key,
  input  logic [BLK_S-1:0]          plaintext,
  input  logic [Nb-1:0]             rounds_total,
  output logic [BLK_S-1:0]          ciphertext,
  output logic [Nb-1:0]             round_no,
  output logic                      busy,
  output logic                      en_o,
  output logic [1:0]                dbg_state
);

  // Handshake: en is a one-cycle start request honoured only when busy is low
  // (or always, with restart); en_o is a one-cycle completion strobe, and
  // ciphertext is valid on that cycle and held until the next block's rounds.

  cipher_state_e    state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             key_req_q, key_req_d;
  logic             round_en_q, round_en_d;
  logic [3:0]       rnd_tag_q, rnd_tag_d;
  logic [BLK_S-1:0] ct_q, ct_d;
  logic             en_o_q, en_o_d;

  logic             start;
  logic             abort;
  logic             apply;
  logic             last_w;
  logic [BLK_S-1:0] round_out;

`ifdef CIPHER_RESTART_EN
  assign start = en;
`else
  assign start = en && !busy;
`endif
  assign abort  = start && busy;
  assign apply  = round_en_q && !abort;
  assign last_w = (rnd_tag_q == rounds_total);

  cipher_round u_round (
    .state_i     (ct_q),
    .round_key_i (round_key),
    .last_i      (last_w),
    .state_o     (round_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CIPHER_IDLE;
      cnt_q      <= '0;
      key_req_q  <= 1'b0;
      round_en_q <= 1'b0;
      rnd_tag_q  <= '0;
      ct_q       <= '0;
      en_o_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_req_q  <= key_req_d;
      round_en_q <= round_en_d;
      rnd_tag_q  <= rnd_tag_d;
      ct_q       <= ct_d;
      en_o_q     <= en_o_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_req_d = key_req_q;
    if (start) begin
      state_d   = CIPHER_RUN;
      cnt_d     = '0;
      key_req_d = 1'b1;
    end else begin
      case (state_q)
        CIPHER_RUN: begin
          key_req_d = 1'b1;
          if (cnt_q == {1'b0, rounds_total}) begin
            state_d   = CIPHER_DRAIN;
            key_req_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        CIPHER_DRAIN: if (round_en_q) state_d = CIPHER_IDLE;
        default: state_d = state_q;
      endcase
    end

    // A restart cancels the in-flight round so the old block never completes.
    round_en_d = key_req_q && !abort;
    rnd_tag_d  = cnt_q[3:0];
    ct_d       = ct_q;
    if (apply) ct_d = (rnd_tag_q == 4'd0) ? (plaintext ^ round_key) : round_out;
    en_o_d     = apply && last_w;
  end

  always_comb begin
    ciphertext = ct_q;
    round_no   = cnt_q[3:0];
    busy       = (state_q != CIPHER_IDLE) || en_o_q;
    en_o       = en_o_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_cipher.sv
// Self-checking bench for cipher: FIPS-197 vectors, sequencing, restart, reset
// abort, back-to-back and random blocks against a behavioural AES model.
module tb_cipher;
  import cipher_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [127:0] round_key;
  logic [127:0] plaintext = '0;
  logic [3:0]   rounds_total = 4'd10;
  logic [127:0] ciphertext;
  logic [3:0]   round_no;
  logic         busy;
  logic         en_o;
  logic [1:0]   dbg_state;

  int           n_tests = 0;
  int           n_fail = 0;
  logic [127:0] ks [16];
  logic [7:0]   tb_sbox [256];
  logic [127:0] exp_ct;
  logic [127:0] exp_q [$];

  cipher dut (
    .clk (clk), .reset (reset), .en (en), .round_key (round_key),
    .plaintext (plaintext), .rounds_total (rounds_total), .ciphertext (ciphertext),
    .round_no (round_no), .busy (busy), .en_o (en_o), .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / key store ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) round_key <= '0;
    else        round_key <= ks[round_no];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    repeat (n) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  // FIPS-197 key expansion; fills the key store, byte j of a round key at [8j+7:8j].
  function automatic void expand(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nk = nr - 6;
    for (int i = 0; i < nk; i++)
      w[i] = {key[8*(4*i) +: 8], key[8*(4*i+1) +: 8], key[8*(4*i+2) +: 8], key[8*(4*i+3) +: 8]};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      ks[r] = '0;
      if (r <= nr)
        for (int j = 0; j < 16; j++) ks[r][8*j +: 8] = w[4*r + j/4][31 - 8*(j%4) -: 8];
    end
  endfunction

  function automatic logic [127:0] ref_cipher(input logic [127:0] pt, input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] out;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[8*(4*c+r) +: 8] ^ ks[0][8*(4*c+r) +: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = tb_sbox[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < nr)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] ^= ks[rnd][8*(4*c+r) +: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) out[8*(4*c+r) +: 8] = s[r][c];
    return out;
  endfunction

  // Hex as written in FIPS-197 (first byte leftmost) to byte-0-in-[7:0] layout.
  function automatic logic [127:0] from_hex(input logic [127:0] h);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = h[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] seq_key(input int nbytes);
    logic [255:0] k = '0;
    for (int i = 0; i < nbytes; i++) k[8*i +: 8] = 8'(i);
    return k;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [127:0] pt, input logic [255:0] key, input int nr);
    plaintext    = pt;
    rounds_total = 4'(nr);
    expand(key, nr);
    exp_ct = ref_cipher(pt, nr);
  endtask

  // Caller raises en for the current cycle; this measures the block from there.
  task automatic run_wait(output int lat, output logic [127:0] ct, output int bcnt, output int ecnt);
    lat = -1; ct = '0; bcnt = 0; ecnt = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) en = 1'b0;
      if (busy) bcnt++;
      if (en_o) begin
        ecnt++;
        if (lat < 0) begin lat = k; ct = ciphertext; end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_tests++; if (ciphertext !== 128'h0) begin n_fail++; $display("FAIL reset_ct got=%h exp=0", ciphertext); end
    n_tests++; if (round_no !== 4'd0) begin n_fail++; $display("FAIL reset_round_no got=%0d exp=0", round_no); end
    n_tests++; if (busy !== 1'b0 || en_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b en_o=%b exp=0,0", busy, en_o); end
    n_tests++; if (dbg_state !== CIPHER_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, CIPHER_IDLE); end
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_fips();
    logic [127:0] exp_c [3];
    logic [127:0] ct;
    int lat, bcnt, ecnt, nr;
    exp_c[0] = from_hex(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    exp_c[1] = from_hex(128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    exp_c[2] = from_hex(128'h8ea2b7ca516745bfeafc49904b496089);
    for (int i = 0; i < 3; i++) begin
      nr = 10 + 2*i;
      load_block(from_hex(128'h00112233445566778899aabbccddeeff), seq_key(4*(nr-6)), nr);
      en = 1'b1;
      run_wait(lat, ct, bcnt, ecnt);
      n_tests++; if (ct !== exp_c[i]) begin n_fail++; $display("FAIL fips_ct nr=%0d got=%h exp=%h", nr, ct, exp_c[i]); end
      n_tests++; if (lat != nr + 3) begin n_fail++; $display("FAIL fips_latency nr=%0d got=%0d exp=%0d", nr, lat, nr + 3); end
      n_tests++; if (bcnt != nr + 3) begin n_fail++; $display("FAIL fips_busy_cycles nr=%0d got=%0d exp=%0d", nr, bcnt, nr + 3); end
      n_tests++; if (ecnt != 1) begin n_fail++; $display("FAIL fips_en_o_count nr=%0d got=%0d exp=1", nr, ecnt); end
    end
  endtask

  task automatic test_sequencing();
    load_block(from_hex(128'h00112233445566778899aabbccddeeff), seq_key(16), 10);
    en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) en = 1'b0;
      n_tests++;
      if (round_no !== 4'(k - 1)) begin n_fail++; $display("FAIL seq_round_no cycle=T+%0d got=%0d exp=%0d", k, round_no, k - 1); end
    end
    repeat (20) step();
  endtask

  task automatic test_restart();
    logic [127:0] exp_first, exp_res, got_ct;
    int eo_cyc, eo_cnt, exp_cyc;
    load_block(from_hex(128'h00112233445566778899aabbccddeeff), seq_key(16), 10);
    exp_first = exp_ct;
    exp_res = exp_first;
    exp_cyc = 13;
    eo_cyc = -1; eo_cnt = 0; got_ct = '0;
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) en = 1'b0;
      if (k == 5) begin
        en = 1'b1;
`ifdef CIPHER_RESTART_EN
        load_block({$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 10);
        exp_res = exp_ct;
        exp_cyc = 18;
`endif
      end
      if (k == 6) en = 1'b0;
      if (en_o) begin
        eo_cnt++;
        if (eo_cyc < 0) begin eo_cyc = k; got_ct = ciphertext; end
      end
    end
    n_tests++; if (eo_cnt != 1) begin n_fail++; $display("FAIL restart_en_o_count got=%0d exp=1", eo_cnt); end
    n_tests++; if (eo_cyc != exp_cyc) begin n_fail++; $display("FAIL restart_latency got=T+%0d exp=T+%0d", eo_cyc, exp_cyc); end
    n_tests++; if (got_ct !== exp_res) begin n_fail++; $display("FAIL restart_ct got=%h exp=%h", got_ct, exp_res); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct;
    int lat, bcnt, ecnt, stray;
    load_block(from_hex(128'h00112233445566778899aabbccddeeff), seq_key(16), 10);
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) en = 1'b0;
    end
    reset = 1'b0;
    #1;
    n_tests++; if (ciphertext !== 128'h0 || round_no !== 4'd0) begin n_fail++; $display("FAIL midreset_data ct=%h round_no=%0d exp=0,0", ciphertext, round_no); end
    n_tests++; if (busy !== 1'b0 || en_o !== 1'b0) begin n_fail++; $display("FAIL midreset_flags busy=%b en_o=%b exp=0,0", busy, en_o); end
    repeat (2) step();
    reset = 1'b1;
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (en_o || busy) stray++;
    end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL midreset_no_completion got=%0d active cycles exp=0", stray); end
    en = 1'b1;
    run_wait(lat, ct, bcnt, ecnt);
    n_tests++; if (ct !== exp_ct || lat != 13) begin n_fail++; $display("FAIL midreset_rerun ct=%h lat=%0d exp=%h lat=13", ct, lat, exp_ct); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_a, ct;
    int lat, bcnt, ecnt, k, nr_b;
    load_block({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 12);
    exp_a = exp_ct;
    en = 1'b1;
    step();
    en = 1'b0;
    k = 1;
    while (!en_o && k < 40) begin step(); k++; end
    n_tests++; if (en_o !== 1'b1 || ciphertext !== exp_a || k != 15) begin n_fail++; $display("FAIL b2b_first ct=%h cyc=%0d exp=%h cyc=15", ciphertext, k, exp_a); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_on_done got=%b exp=1", busy); end
    nr_b = 10 + 2*$urandom_range(0, 2);
    load_block({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, nr_b);
    en = 1'b1;
`ifndef CIPHER_RESTART_EN
    step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_en_ignored busy=%b exp=0", busy); end
`endif
    run_wait(lat, ct, bcnt, ecnt);
    n_tests++; if (ct !== exp_ct || lat != nr_b + 3) begin n_fail++; $display("FAIL b2b_second ct=%h lat=%0d exp=%h lat=%0d", ct, lat, exp_ct, nr_b + 3); end
  endtask

  task automatic test_random();
    logic [127:0] ct, exp;
    int lat, bcnt, ecnt, nr;
    for (int i = 0; i < 6; i++) begin
      nr = 10 + 2*$urandom_range(0, 2);
      load_block({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, nr);
      exp_q.push_back(exp_ct);
      repeat ($urandom_range(0, 3)) step();
      en = 1'b1;
      run_wait(lat, ct, bcnt, ecnt);
      exp = exp_q.pop_front();
      n_tests++; if (ct !== exp) begin n_fail++; $display("FAIL random_ct blk=%0d nr=%0d got=%h exp=%h", i, nr, ct, exp); end
      n_tests++; if (lat != nr + 3 || ecnt != 1) begin n_fail++; $display("FAIL random_timing blk=%0d lat=%0d en_o_count=%0d exp=%0d,1", i, lat, ecnt, nr + 3); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    build_sbox();
    for (int r = 0; r < 16; r++) ks[r] = '0;
    test_reset();
    test_fips();
    test_sequencing();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
